cv32e40p_rf_wb_arbiter: RTL and testbench



---
 rtl/cv32e40p_rf_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_cv32e40p_rf_wb_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_rf_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cv32e40p_rf_wb_arbiter                                                 |
// | W2 write-back arbiter: fixed-priority LSU plus round-robin producers,   |
// | one-entry output stage and pending-write scoreboard.                    |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module cv32e40p_rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 3
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid_i,
    output logic [NUM_REQ-1:0]                     req_ready_o,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_data_i,
    input  logic                                   hold_i,
    output logic [ADDR_WIDTH-1:0]                  waddr_b_o,
    output logic [DATA_WIDTH-1:0]                  wdata_b_o,
    output logic                                   we_b_o,
    output logic [(2**ADDR_WIDTH)-1:0]             busy_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CW    = PTR_W + 1;
    localparam int NREG  = 2**ADDR_WIDTH;

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  stage_valid_q, stage_valid_d;
    logic [ADDR_WIDTH-1:0] stage_addr_q, stage_addr_d;
    logic [DATA_WIDTH-1:0] stage_data_q, stage_data_d;
    logic [NREG-1:0]       busy_q, busy_d;

    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      win_idx;
    logic                  found;
    logic [CW-1:0]         cand;
    logic                  can_accept;
    logic                  transfer;
    logic                  win_is_x0;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    // Requester 0 wins outright; otherwise scan 1..NUM_REQ-1 starting at rr_ptr.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        if (req_valid_i[0]) begin
            grant[0] = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ-1; k++) begin
                cand = {1'b0, rr_ptr_q} + CW'(k);
                if (cand > CW'(NUM_REQ-1)) begin
                    cand = cand - CW'(NUM_REQ-1);
                end
                if (!found && req_valid_i[cand[PTR_W-1:0]]) begin
                    found   = 1'b1;
                    win_idx = cand[PTR_W-1:0];
                end
            end
            if (found) begin
                grant[win_idx] = 1'b1;
            end
        end
    end

    assign win_addr    = req_addr_i[win_idx];
    assign win_data    = req_data_i[win_idx];
    assign win_is_x0   = (win_addr == '0);
    assign can_accept  = !stage_valid_q || !hold_i;
    assign req_ready_o = grant & {NUM_REQ{can_accept}};
    assign transfer    = |req_ready_o;

    assign we_b_o    = stage_valid_q && !hold_i;
    assign waddr_b_o = stage_addr_q;
    assign wdata_b_o = stage_data_q;
    assign busy_o    = busy_q;

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        stage_valid_d = stage_valid_q;
        stage_addr_d  = stage_addr_q;
        stage_data_d  = stage_data_q;
        busy_d        = busy_q;

        if (transfer && (win_idx != '0)) begin
            rr_ptr_d = (win_idx == PTR_W'(NUM_REQ-1)) ? PTR_W'(1) : win_idx + PTR_W'(1);
        end

        // An x0 winner is consumed but leaves the stage empty.
        if (transfer) begin
            stage_valid_d = !win_is_x0;
            stage_addr_d  = win_addr;
            stage_data_d  = win_data;
        end else if (we_b_o) begin
            stage_valid_d = 1'b0;
        end

        // Clear before set so a same-address refill keeps the bit high.
        if (we_b_o) begin
            busy_d[stage_addr_q] = 1'b0;
        end
        if (transfer && !win_is_x0) begin
            busy_d[win_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= PTR_W'(1);
            stage_valid_q <= 1'b0;
            stage_addr_q  <= '0;
            stage_data_q  <= '0;
            busy_q        <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            stage_valid_q <= stage_valid_d;
            stage_addr_q  <= stage_addr_d;
            stage_data_q  <= stage_data_d;
            busy_q        <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_cv32e40p_rf_wb_arbiter                                              |
// | Directed self-checking bench for the W2 write-back arbiter.            |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_cv32e40p_rf_wb_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NR = 3;

    logic                     clk;
    logic                     rst_n;
    logic [NR-1:0]            req_valid;
    logic [NR-1:0]            req_ready;
    logic [NR-1:0][AW-1:0]    req_addr;
    logic [NR-1:0][DW-1:0]    req_data;
    logic                     hold;
    logic [AW-1:0]            waddr_b;
    logic [DW-1:0]            wdata_b;
    logic                     we_b;
    logic [(2**AW)-1:0]       busy;

    int n_checks;
    int n_fail;

    cv32e40p_rf_wb_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .hold_i      (hold),
        .waddr_b_o   (waddr_b),
        .wdata_b_o   (wdata_b),
        .we_b_o      (we_b),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        hold      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;

        // Reset state
        tick(); tick();
        settle();
        chk("rst_we",    64'(we_b),      64'd0);
        chk("rst_waddr", 64'(waddr_b),   64'd0);
        chk("rst_wdata", 64'(wdata_b),   64'd0);
        chk("rst_busy",  busy,           64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single request from requester 1
        req_valid[1] = 1'b1; req_addr[1] = 6'd5; req_data[1] = 32'hDEADBEEF;
        settle();
        chk("single_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        settle();
        chk("single_we",    64'(we_b),    64'd1);
        chk("single_waddr", 64'(waddr_b), 64'd5);
        chk("single_wdata", 64'(wdata_b), 64'hDEADBEEF);
        chk("single_busy",  busy,         64'd1 << 5);
        tick();
        settle();
        chk("single_busy_clr", busy,       64'd0);
        chk("single_we_clr",   64'(we_b),  64'd0);

        // Priority: rr_ptr is 2 after the requester-1 win above, so once
        // requester 0 drops the round-robin order must start at 2.
        req_addr[0] = 6'd10; req_data[0] = 32'hA0;
        req_addr[1] = 6'd11; req_data[1] = 32'hA1;
        req_addr[2] = 6'd12; req_data[2] = 32'hA2;
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("prio_req0", 64'(req_ready), 64'b001);
            tick();
        end
        settle();
        chk("prio_waddr", 64'(waddr_b), 64'd10);
        req_valid = 3'b110;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr_grant", 64'(req_ready), (i % 2 == 0) ? 64'b100 : 64'b010);
            tick();
        end
        req_valid = '0;
        tick(); tick();
        settle();
        chk("rr_drained_busy", busy, 64'd0);

        // Hold with a full stage (rr_ptr now 2; only requester 1 valid)
        req_valid[1] = 1'b1; req_addr[1] = 6'd7; req_data[1] = 32'h77;
        tick();
        req_valid = 3'b100; req_addr[2] = 6'd8; req_data[2] = 32'h88;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hold_we",    64'(we_b),      64'd0);
            chk("hold_ready", 64'(req_ready), 64'd0);
            chk("hold_busy7", 64'(busy[7]),   64'd1);
            tick();
        end
        hold = 1'b0;
        settle();
        chk("rel_we",    64'(we_b),      64'd1);
        chk("rel_waddr", 64'(waddr_b),   64'd7);
        chk("rel_ready", 64'(req_ready), 64'b100);
        tick();
        req_valid = '0;
        settle();
        chk("rel2_waddr", 64'(waddr_b), 64'd8);
        chk("rel2_wdata", 64'(wdata_b), 64'h88);
        chk("rel2_busy",  busy,         64'd1 << 8);
        tick();

        // Hold with an empty stage: one transfer goes in, the next waits
        hold = 1'b1;
        req_valid = 3'b001; req_addr[0] = 6'd4; req_data[0] = 32'h44;
        settle();
        chk("hempty_ready", 64'(req_ready), 64'b001);
        tick();
        req_addr[0] = 6'd6; req_data[0] = 32'h66;
        settle();
        chk("hempty_ready2", 64'(req_ready), 64'd0);
        chk("hempty_we",     64'(we_b),      64'd0);
        chk("hempty_busy",   busy,           64'd1 << 4);
        hold = 1'b0;
        settle();
        chk("hempty_rel_we", 64'(we_b),      64'd1);
        chk("hempty_rel_rd", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        settle();
        chk("hempty_waddr6", 64'(waddr_b), 64'd6);
        tick();

        // x0 drop from requester 2
        req_valid = 3'b100; req_addr[2] = 6'd0; req_data[2] = 32'h1234;
        settle();
        chk("x0_ready", 64'(req_ready), 64'b100);
        tick();
        req_valid = '0;
        settle();
        chk("x0_we",   64'(we_b), 64'd0);
        chk("x0_busy", busy,      64'd0);
        tick();

        // Same-address set/clear collision
        req_valid = 3'b010; req_addr[1] = 6'd9; req_data[1] = 32'hB1;
        settle();
        chk("col_ready1", 64'(req_ready), 64'b010);
        tick();
        req_data[1] = 32'hB2;
        settle();
        chk("col_we1",    64'(we_b),      64'd1);
        chk("col_ready2", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        settle();
        chk("col_busy9", busy,          64'd1 << 9);
        chk("col_wdata", 64'(wdata_b),  64'hB2);
        tick();
        settle();
        chk("col_busy_clr", busy, 64'd0);

        // Reset mid-operation (rr_ptr is 2 beforehand)
        req_valid = 3'b010; req_addr[1] = 6'd3; req_data[1] = 32'h33;
        tick();
        req_valid = '0;
        settle();
        chk("mid_busy3", busy,      64'd1 << 3);
        chk("mid_we",    64'(we_b), 64'd1);
        rst_n = 1'b0;
        settle();
        chk("arst_we",    64'(we_b),    64'd0);
        chk("arst_busy",  busy,         64'd0);
        chk("arst_waddr", 64'(waddr_b), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        req_valid = 3'b110; req_addr[1] = 6'd1; req_addr[2] = 6'd2;
        settle();
        chk("arst_rr", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
